// File: rtl/mux_sched_pkg.sv
// Shared types and the rotating-priority pick function for the 4:1 mux scheduler.
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Scans start, start+1, ... (mod 4); returns start when nothing is set.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   start);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        idx = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder over four requests.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    assign idx = rr_pick(req, start);
    assign any = |req;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of a shared 4:1 mux select with bounded tenure.
// Define SWITCH_COUNT_EN to add the saturating select-change counter (switch_cnt/switch_clr).
module mux4_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid
`ifdef SWITCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]   switch_cnt,
    input  logic               switch_clr
`endif
);

    localparam int TEN_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TEN_W-1:0] HOLD_T = TEN_W'(HOLD_CYCLES);
    localparam logic [TEN_W-1:0] TEN_ONE = TEN_W'(1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || CNT_W < 1) begin : g_bad_param
        $error("mux4_rr_sched: HOLD_CYCLES must be 1..255 and CNT_W >= 1");
    end

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 vld_q, vld_d;
    logic [TEN_W-1:0]     tenure_q, tenure_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 take;

    // While granted last_q equals the owner, so one encoder serves every hand-over.
    rr_pick4 u_pick (
        .req   (req),
        .start (last_q + SEL_W'(1)),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        vld_d    = vld_q;
        tenure_d = tenure_q;
        last_d   = last_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else if (tenure_q < HOLD_T) begin
                    tenure_d = tenure_q + TEN_ONE;
                end else begin
                    take = 1'b1;
                end
            end
        endcase
        // A fresh grant may re-select the current owner; sel then stays put.
        if (take) begin
            state_d  = GRANT;
            sel_d    = pick_idx;
            gnt_d    = NUM_REQ'(1) << pick_idx;
            vld_d    = 1'b1;
            tenure_d = TEN_ONE;
            last_d   = pick_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            tenure_q <= '0;
            last_q   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            vld_q    <= vld_d;
            tenure_q <= tenure_d;
            last_q   <= last_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;

`ifdef SWITCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (switch_clr) begin
            cnt_d = '0;
        end else if ((sel_d != sel_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign switch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: per-cycle reference model plus directed literal checks.
module tb_mux4_rr_sched;

    localparam int HOLD   = 4;
    localparam int CW     = 16;
    localparam int CMAX   = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
`ifdef SWITCH_COUNT_EN
    logic [CW-1:0] switch_cnt;
    logic          switch_clr;
`endif

    int total = 0;
    int bad   = 0;

    mux4_rr_sched #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
`ifdef SWITCH_COUNT_EN
        ,
        .switch_cnt(switch_cnt),
        .switch_clr(switch_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner/tenure/last bookkeeping straight from the arbitration rules.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_sel   = 0;
    int m_ten   = 0;
    int m_last  = 3;
    int m_cnt   = 0;

    function automatic int mpick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  nxt;
        bit  chg;
        bit  clr;
        chg = 0;
        nxt = -1;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_sel = 0; m_ten = 0; m_last = 3; m_cnt = 0;
            return;
        end
`ifdef SWITCH_COUNT_EN
        clr = switch_clr;
`else
        clr = 0;
`endif
        if (!m_busy) begin
            if (req != 0) nxt = mpick(req, (m_last + 1) % 4);
        end else if (!req[m_owner]) begin
            if (req != 0) nxt = mpick(req, (m_owner + 1) % 4);
            else m_busy = 0;
        end else if (m_ten < HOLD) begin
            m_ten++;
        end else begin
            nxt = mpick(req, (m_owner + 1) % 4);
        end
        if (nxt >= 0) begin
            chg     = (nxt != m_sel);
            m_owner = nxt;
            m_sel   = nxt;
            m_last  = nxt;
            m_ten   = 1;
            m_busy  = 1;
        end
        if (clr) m_cnt = 0;
        else if (chg && m_cnt < CMAX) m_cnt++;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("m_sel", sel, m_sel);
            chk("m_vld", gnt_valid, m_busy);
            chk("onehot", $onehot0(gnt), 1);
`ifdef SWITCH_COUNT_EN
            chk("m_cnt", switch_cnt, m_cnt);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        int eo;
        rst = 1'b1;
        req = 4'b0000;
`ifdef SWITCH_COUNT_EN
        switch_clr = 1'b0;
`endif
        cyc(2);
        rst = 1'b0;

        cyc(3);
        chk("idle_gnt", gnt, 0);
        chk("idle_sel", sel, 0);
        chk("idle_vld", gnt_valid, 0);

        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            eo = (k / 4) % 4;
            chk("fair_sel", sel, eo);
            chk("fair_gnt", gnt, 32'd1 << eo);
        end

        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_vld", gnt_valid, 0);
        rst = 1'b0;
        cyc(1);
        chk("restart_gnt", gnt, 4'b0001);

        do_reset();
        req = 4'b0100;
        cyc(1);
        chk("early_gnt1", gnt, 4'b0100);
        cyc(1);
        chk("early_gnt2", gnt, 4'b0100);
        req = 4'b0000;
        cyc(1);
        chk("early_rel_gnt", gnt, 0);
        chk("early_rel_vld", gnt_valid, 0);
        chk("early_rel_sel", sel, 2);
        cyc(2);
        chk("idle_hold_sel", sel, 2);
`ifdef SWITCH_COUNT_EN
        chk("early_cnt", switch_cnt, 1);
`endif

        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("sole_gnt", gnt, 4'b0010);
            chk("sole_sel", sel, 1);
        end
`ifdef SWITCH_COUNT_EN
        chk("sole_cnt", switch_cnt, 1);
`endif

        do_reset();
        req = 4'b1000;
        cyc(1);
        chk("wrap_own3", gnt, 4'b1000);
        req = 4'b0011;
        cyc(1);
        chk("wrap_gnt", gnt, 4'b0001);
        chk("wrap_vld", gnt_valid, 1);
        req = 4'b0010;
        cyc(1);
        chk("wrap_next", gnt, 4'b0010);
        req = 4'b0100;
        cyc(1);
        chk("chg4_gnt", gnt, 4'b0100);
        req = 4'b1000;
        cyc(1);
        chk("chg5_gnt", gnt, 4'b1000);
`ifdef SWITCH_COUNT_EN
        chk("cnt5", switch_cnt, 5);
        switch_clr = 1'b1;
        req = 4'b0001;
        cyc(1);
        switch_clr = 1'b0;
        chk("clr_cnt", switch_cnt, 0);
        chk("clr_sel", sel, 0);
        for (int k = 0; k < CMAX + 5; k++) begin
            req = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            cyc(1);
        end
        chk("sat_cnt", switch_cnt, 16'hFFFF);
        req = 4'b0010;
        cyc(2);
        chk("sat_hold", switch_cnt, 16'hFFFF);
`endif

        req = 4'b0000;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
